// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, default instruction memory depth and the
// program loader state encoding.
package cpu_pkg;

  localparam int WORD_W             = 32;
  localparam int IMEM_DEPTH_DEFAULT = 256;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CHK,
    DONE,
    ERROR
  } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream into the program loader.
// Handshake: a byte transfers on a rising clk edge where in_valid and in_ready
// are both high; in_data is don't-care on any other cycle.
interface imem_loader_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);

endinterface

// File: rtl/byte_to_word_packer.sv
// Packs accepted bytes MSB-first into 32-bit words; word_valid pulses
// combinationally with the byte that completes each word.
module byte_to_word_packer
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [23:0] shift_q;
  logic [1:0]  idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (clear) begin
      idx_q <= '0;
    end else if (byte_valid) begin
      shift_q <= {shift_q[15:0], byte_data};
      idx_q   <= idx_q + 2'd1;
    end
  end

  assign word_valid = byte_valid && (idx_q == 2'd3);
  assign word       = {shift_q, byte_data};

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: length-prefixed byte frame -> instruction memory
// writes, holding the core in reset until a good image is in place.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  imem_loader_if.slave        bs,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_waddr,
  output logic [WORD_W-1:0]   imem_wdata,
  output logic                core_hold,
  output logic                done,
  output logic                error,
  output logic [ADDR_W:0]     words_loaded,
  output loader_state_e       dbg_state
);

  localparam int CNT_W = ADDR_W + 1;

  loader_state_e      state_q;
  logic               in_ready_q;
  logic               imem_we_q;
  logic [ADDR_W-1:0]  imem_waddr_q;
  logic [WORD_W-1:0]  imem_wdata_q;
  logic               core_hold_q;
  logic               done_q;
  logic               error_q;
  logic [CNT_W-1:0]   words_loaded_q;
  logic [CNT_W-1:0]   len_q;
  logic [7:0]         len_hi_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         xor_q;
`endif

  logic               accept;
  logic [15:0]        n_word;
  logic [CNT_W-1:0]   words_next;
  logic               pk_clear;
  logic               pk_valid;
  logic               pk_word_valid;
  logic [WORD_W-1:0]  pk_word;

  assign accept     = bs.in_valid && in_ready_q;
  assign n_word     = {len_hi_q, bs.in_data};
  assign words_next = words_loaded_q + CNT_W'(1);
  assign pk_clear   = accept && (state_q == LEN_LO);
  assign pk_valid   = accept && (state_q == DATA);

  byte_to_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pk_clear),
    .byte_valid (pk_valid),
    .byte_data  (bs.in_data),
    .word_valid (pk_word_valid),
    .word       (pk_word)
  );

  // done/core_hold follow entry into DONE by one cycle, so the core is only
  // released after the final memory write has committed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= LEN_HI;
      in_ready_q     <= 1'b1;
      imem_we_q      <= 1'b0;
      imem_waddr_q   <= '0;
      imem_wdata_q   <= '0;
      core_hold_q    <= 1'b1;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      words_loaded_q <= '0;
      len_q          <= '0;
      len_hi_q       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q          <= '0;
`endif
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        LEN_HI: begin
          if (accept) begin
            len_hi_q <= bs.in_data;
            state_q  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            if (n_word == 16'd0) begin
              state_q    <= DONE;
              in_ready_q <= 1'b0;
            end else if (n_word > 16'(IMEM_DEPTH)) begin
              state_q    <= ERROR;
              in_ready_q <= 1'b0;
            end else begin
              len_q          <= CNT_W'(n_word);
              words_loaded_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
              xor_q          <= '0;
`endif
              state_q        <= DATA;
            end
          end
        end
        DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (accept) xor_q <= xor_q ^ bs.in_data;
`endif
          if (pk_word_valid) begin
            imem_we_q      <= 1'b1;
            imem_waddr_q   <= words_loaded_q[ADDR_W-1:0];
            imem_wdata_q   <= pk_word;
            words_loaded_q <= words_next;
            if (words_next == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_q    <= CHK;
`else
              state_q    <= DONE;
              in_ready_q <= 1'b0;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            state_q    <= (bs.in_data == xor_q) ? DONE : ERROR;
          end
        end
`endif
        DONE: begin
          if (start) begin
            state_q        <= LEN_HI;
            in_ready_q     <= 1'b1;
            core_hold_q    <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            words_loaded_q <= '0;
          end else begin
            done_q      <= 1'b1;
            core_hold_q <= 1'b0;
          end
        end
        ERROR: begin
          if (start) begin
            state_q        <= LEN_HI;
            in_ready_q     <= 1'b1;
            core_hold_q    <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            words_loaded_q <= '0;
          end else begin
            error_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= LEN_HI;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bs.in_ready  = in_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_waddr   = imem_waddr_q;
  assign imem_wdata   = imem_wdata_q;
  assign core_hold    = core_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and randomized frames checked against a
// frame-level reference model (expected write queue + final outcome).
module tb_imem_loader;
  import cpu_pkg::*;

  localparam int DEPTH = 256;
  localparam int AW    = $clog2(DEPTH);

  // clock / reset
  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if bs ();

  logic            imem_we;
  logic [AW-1:0]   imem_waddr;
  logic [31:0]     imem_wdata;
  logic            core_hold;
  logic            done;
  logic            error;
  logic [AW:0]     words_loaded;
  loader_state_e   dbg_state;

  imem_loader #(.IMEM_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bs           (bs),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .core_hold    (core_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded),
    .dbg_state    (dbg_state)
  );

  // scoreboard
  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_fail   = 0;
  logic [31:0]   exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            we_set   = 0;
  int            we_seen  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // write monitor, run at every negedge the stimulus waits on
  task automatic mon();
    bit due;
    if (!rst) return;
    due = (we_set != we_seen);
    if (imem_we || due) begin
      check("we_timing", imem_we, due);
      if (imem_we) begin
        check("write_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          check("waddr", imem_waddr, exp_addr_q.pop_front());
          check("wdata", imem_wdata, exp_q.pop_front());
        end
      end
      we_seen = we_set;
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
  endtask

  // driver
  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse_start, output bit ok);
    for (int g = 0; g < gap; g++) begin
      step();
      bs.in_valid = 1'b0;
      bs.in_data  = 8'($urandom);
      start       = 1'b0;
    end
    step();
    bs.in_valid = 1'b1;
    bs.in_data  = b;
    start       = pulse_start;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (bs.in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      step();
      start = 1'b0;
    end
  endtask

  // model: frame -> expected writes and outcome, then drive and check
  task automatic run_frame(input logic [7:0] frame[$], input int gap_lo, input int gap_hi,
                           input int start_idx, input bit bad_chk);
    logic [7:0] fr[$];
    logic [7:0] x;
    int         n;
    int         exp_wl;
    bit         valid_len, exp_done, exp_err, ok;
    fr        = frame;
    n         = {fr[0], fr[1]};
    x         = 8'h00;
    valid_len = (n >= 1) && (n <= DEPTH);
    exp_done  = (n == 0);
    exp_err   = (n > DEPTH);
    exp_wl    = 0;
    if (valid_len) begin
      for (int k = 0; k < n; k++) begin
        exp_q.push_back({fr[2+4*k], fr[3+4*k], fr[4+4*k], fr[5+4*k]});
        exp_addr_q.push_back(AW'(k));
        for (int m = 0; m < 4; m++) x ^= fr[2+4*k+m];
      end
      exp_wl = n;
`ifdef IMEM_LOADER_CHECKSUM_EN
      fr.push_back(bad_chk ? (x ^ 8'h01) : x);
      exp_done = !bad_chk;
      exp_err  = bad_chk;
`else
      exp_done = 1'b1;
`endif
    end
    for (int i = 0; i < fr.size(); i++) begin
      send_byte(fr[i], $urandom_range(gap_hi, gap_lo), (i == start_idx), ok);
      check("byte_accepted", ok, 1'b1);
      if (!ok) break;
      if (valid_len && i >= 2 && (i - 2) < 4 * n && ((i - 2) % 4) == 3) we_set++;
    end
    step();
    bs.in_valid = 1'b0;
    start       = 1'b0;
    check("ready_low_at_end", bs.in_ready, 1'b0);
    check("hold_before_release", core_hold, 1'b1);
    check("done_not_early", done, 1'b0);
    step();
    check("done", done, exp_done);
    check("error", error, exp_err);
    check("core_hold", core_hold, !exp_done);
    check("words_loaded", words_loaded, exp_wl);
    check("final_state", dbg_state, exp_done ? DONE : ERROR);
    repeat (3) begin
      step();
      bs.in_valid = 1'b1;
      bs.in_data  = 8'($urandom);
      check("no_accept_after_end", bs.in_ready, 1'b0);
    end
    step();
    bs.in_valid = 1'b0;
    check("writes_drained", exp_q.size(), 0);
    check("words_loaded_stable", words_loaded, exp_wl);
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_hold", core_hold, 1'b1);
    check("restart_done", done, 1'b0);
    check("restart_error", error, 1'b0);
    check("restart_ready", bs.in_ready, 1'b1);
    check("restart_words", words_loaded, 0);
    check("restart_state", dbg_state, LEN_HI);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fr[$];
    logic [7:0] pre[$];
    bit         ok;
    int         n;

    bs.in_valid = 1'b0;
    bs.in_data  = 8'h00;

    // reset values
    step();
    step();
    check("rst_ready", bs.in_ready, 1'b1);
    check("rst_we", imem_we, 1'b0);
    check("rst_waddr", imem_waddr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_hold", core_hold, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_words", words_loaded, 0);
    check("rst_state", dbg_state, LEN_HI);
    rst = 1'b1;
    step();

    // normal, back-to-back then alternate-cycle valid
    fr = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    run_frame(fr, 0, 0, -1, 1'b0);
    run_frame(fr, 1, 1, -1, 1'b0);

    // zero length, oversize
    fr = {8'h00, 8'h00};
    run_frame(fr, 0, 0, -1, 1'b0);
    fr = {8'h01, 8'h01};
    run_frame(fr, 0, 0, -1, 1'b0);
    fr = {8'hFF, 8'hFF};
    run_frame(fr, 0, 1, -1, 1'b0);

    // full-depth image
    fr = {8'h01, 8'h00};
    for (int i = 0; i < 4 * DEPTH; i++) fr.push_back(8'($urandom));
    run_frame(fr, 0, 0, -1, 1'b0);

    // reset after 6 data bytes, then a fresh frame loads from address 0
    pre = {8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    exp_q.push_back(32'hAABBCCDD);
    exp_addr_q.push_back('0);
    for (int i = 0; i < pre.size(); i++) begin
      send_byte(pre[i], 0, 1'b0, ok);
      check("pre_byte_accepted", ok, 1'b1);
      if (i == 5) we_set++;
    end
    step();
    bs.in_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("midrst_hold", core_hold, 1'b1);
    check("midrst_ready", bs.in_ready, 1'b1);
    check("midrst_words", words_loaded, 0);
    check("midrst_we", imem_we, 1'b0);
    check("midrst_state", dbg_state, LEN_HI);
    check("midrst_drained", exp_q.size(), 0);
    step();
    rst = 1'b1;
    step();
    fr = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    run_frame(fr, 0, 0, -1, 1'b0);

    // start while receiving is ignored
    run_frame(fr, 0, 1, 5, 1'b0);

    // checksum frames (plain one-word loads when the checksum is not built in)
    fr = {8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    run_frame(fr, 0, 0, -1, 1'b0);
    run_frame(fr, 0, 0, -1, 1'b1);

    // randomized frames
    for (int r = 0; r < 8; r++) begin
      n  = $urandom_range(6, 1);
      fr = {8'h00, 8'(n)};
      for (int i = 0; i < 4 * n; i++) fr.push_back(8'($urandom));
      run_frame(fr, 0, 2, $urandom_range(4 * n + 2, 0), 1'($urandom_range(1, 0)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
